// File: rtl/spi_slave_tx_feeder_pkg.sv
// Shared definitions for the SPI slave transmit feeder: FSM encoding,
// transmitter idle code and a constant-evaluable clog2.
package spi_slave_tx_feeder_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_ARM     = 3'd2;
    localparam logic [2:0] ST_HANDOFF = 3'd3;
    localparam logic [2:0] ST_BUSY    = 3'd4;

    // Transmitter load FSM reports 0 when it can take a new word.
    localparam logic [4:0] TX_IDLE = 5'd0;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_slave_tx_feeder_if.sv
// Register-side and transmitter-side signals of the transmit feeder.
interface spi_slave_tx_feeder_if #(
    parameter int data_len   = 8,
    parameter int fifo_depth = 16
);
    import spi_slave_tx_feeder_pkg::*;

    localparam int LVL_W = clog2(fifo_depth) + 1;

    logic                tx_en;
    logic                flush;
    logic                wr_en;
    logic [data_len-1:0] wr_data;
    logic                clr_status;
    logic [4:0]          state_tx;
    logic                qvld;

    logic [data_len-1:0] din;
    logic                start;
    logic [LVL_W-1:0]    level;
    logic                full;
    logic                empty;
    logic                overflow;
    logic                underrun;
    logic                busy;

    modport master (
        output tx_en, flush, wr_en, wr_data, clr_status, state_tx, qvld,
        input  din, start, level, full, empty, overflow, underrun, busy
    );

    modport slave (
        input  tx_en, flush, wr_en, wr_data, clr_status, state_tx, qvld,
        output din, start, level, full, empty, overflow, underrun, busy
    );

endinterface

// File: rtl/spi_sync_fifo.sv
// Synchronous circular FIFO with show-ahead read data, flush and level.
module spi_sync_fifo
    import spi_slave_tx_feeder_pkg::*;
#(
    parameter int  data_w = 8,
    parameter int  depth  = 16,
    localparam int PTR_W  = clog2(depth),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [data_w-1:0] wr_data,
    input  logic              rd_en,
    output logic [data_w-1:0] rd_data,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty,
    output logic              wr_rej
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(depth);

    logic [data_w-1:0] mem [depth];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_rd;
    logic              do_wr;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO still takes the write.
    assign do_rd  = rd_en & ~empty & ~flush;
    assign do_wr  = wr_en & (~full | do_rd) & ~flush;
    assign wr_rej = wr_en & ~do_wr & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/spi_slave_tx_feeder.sv
// Feeds queued words to the SPI slave transmitter, one launch per frame,
// paced by the transmitter's load state and frame-complete level.
module spi_slave_tx_feeder
    import spi_slave_tx_feeder_pkg::*;
#(
    parameter int data_len     = 8,
    parameter int fifo_depth   = 16,
    parameter int start_cycles = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_slave_tx_feeder_if.slave  bus
);

    localparam int LVL_W = clog2(fifo_depth) + 1;
    localparam int CNT_W = clog2(start_cycles + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(start_cycles - 1);

    logic [2:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [data_len-1:0] din_r;
    logic [data_len-1:0] fifo_rd_data;
    logic [LVL_W-1:0]    level;
    logic                full;
    logic                empty;
    logic                wr_rej;
    logic                tx_idle;
    logic                pop;
    logic                qvld_d;
    logic                qv_rise;
    logic                underrun_set;
    logic                overflow_r;
    logic                underrun_r;

    assign tx_idle      = (bus.state_tx == TX_IDLE);
    assign pop          = (state == ST_IDLE) & bus.tx_en & ~empty & tx_idle & ~bus.flush;
    assign qv_rise      = bus.qvld & ~qvld_d;
    assign underrun_set = (state == ST_BUSY) & qv_rise & empty;

    spi_sync_fifo #(
        .data_w (data_len),
        .depth  (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .level   (level),
        .full    (full),
        .empty   (empty),
        .wr_rej  (wr_rej)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            din_r <= '0;
        end else if (bus.flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            if (pop) din_r <= fifo_rd_data;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state <= ST_LOAD;
                        cnt   <= '0;
                    end
                end
                // Counter freezes while tx_en is low so the strobe resumes its full length.
                ST_LOAD: begin
                    if (bus.tx_en) begin
                        if (cnt == CNT_LAST) state <= ST_ARM;
                        else                 cnt   <= cnt + 1'b1;
                    end
                end
                ST_ARM:     if (!tx_idle) state <= ST_HANDOFF;
                ST_HANDOFF: if (tx_idle)  state <= ST_BUSY;
                ST_BUSY:    if (qv_rise)  state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Set events take precedence over clr_status.
    always_ff @(posedge clk) begin
        if (rst) begin
            qvld_d     <= 1'b0;
            overflow_r <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            qvld_d <= bus.qvld;
            if (wr_rej)              overflow_r <= 1'b1;
            else if (bus.clr_status) overflow_r <= 1'b0;
            if (underrun_set)        underrun_r <= 1'b1;
            else if (bus.clr_status) underrun_r <= 1'b0;
        end
    end

    assign bus.din      = din_r;
    assign bus.start    = (state == ST_LOAD) & bus.tx_en;
    assign bus.level    = level;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.overflow = overflow_r;
    assign bus.underrun = underrun_r;
    assign bus.busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_tx_feeder.sv
// Bench for spi_slave_tx_feeder: table-driven FIFO status vectors, a launch
// scoreboard and hand-written transmitter handshake sequences.
module tb_spi_slave_tx_feeder;

    localparam int DEPTH = 4;
    localparam int SC    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_tx_feeder_if #(.data_len(8), .fifo_depth(DEPTH)) bus ();

    spi_slave_tx_feeder #(
        .data_len     (8),
        .fifo_depth   (DEPTH),
        .start_cycles (SC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       tx_en;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       clr;
        logic       acc;
        logic [6:0] exp_status;
    } vec_t;

    vec_t       tbl [9];
    logic [7:0] sb [$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_pulses = 0;
    bit         frame_open = 0;
    bit         abort_ok = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch monitor: each start rise must match the oldest queued word.
    logic       start_q = 1'b0;
    int         run_len = 0;
    logic [7:0] launched = 8'h00;
    always @(negedge clk) begin
        if (bus.start && !start_q) begin
            n_pulses++;
            if (frame_open) check("start_before_qvld_rise", 1, 0);
            if (sb.size() == 0) check("unexpected_start", 1, 0);
            else check("launch_din", bus.din, sb.pop_front());
            frame_open = 1;
            run_len    = 1;
            launched   = bus.din;
        end else if (bus.start) begin
            run_len++;
            check("din_stable", bus.din, launched);
        end else if (start_q) begin
            if (!abort_ok) check("start_len", run_len, SC);
            abort_ok = 0;
        end
        start_q = bus.start;
    end

    task automatic write_word(input logic [7:0] d, input bit accept);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        if (accept) sb.push_back(d);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic launch_to_busy();
        int n;
        n = 0;
        while (!bus.start && n < 40) begin tick(); n++; end
        check("launch_seen", bus.start, 1);
        n = 0;
        while (bus.start && n < 40) begin tick(); n++; end
        bus.state_tx = 5'd3;
        tick();
        tick();
        bus.state_tx = 5'd0;
        tick();
    endtask

    task automatic serve_frame();
        launch_to_busy();
        tick();
        tick();
        check("busy_in_frame", {bus.busy, bus.start}, 2'b10);
        bus.qvld = 1'b1;
        tick();
        frame_open = 0;
        check("busy_clears", bus.busy, 0);
        bus.qvld = 1'b0;
        tick();
    endtask

    localparam logic [16:0] RESET_VAL = {8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    function automatic logic [16:0] all_out();
        return {bus.din, bus.start, bus.level, bus.empty, bus.full,
                bus.overflow, bus.underrun, bus.busy};
    endfunction

    initial begin
        int p0;
        int seen;
        tbl[0] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, {3'd1, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[1] = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, {3'd2, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[2] = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, {3'd3, 1'b0, 1'b0, 1'b0, 1'b0}};
        tbl[3] = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, {3'd4, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[4] = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b0, {3'd4, 1'b1, 1'b0, 1'b1, 1'b0}};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, {3'd4, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[6] = '{1'b0, 1'b1, 8'h06, 1'b1, 1'b0, {3'd4, 1'b1, 1'b0, 1'b1, 1'b0}};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, {3'd4, 1'b1, 1'b0, 1'b0, 1'b0}};
        tbl[8] = '{1'b1, 1'b1, 8'h07, 1'b0, 1'b1, {3'd4, 1'b1, 1'b0, 1'b0, 1'b0}};

        bus.tx_en = 0; bus.flush = 0; bus.wr_en = 0; bus.wr_data = 0;
        bus.clr_status = 0; bus.state_tx = 0; bus.qvld = 0;
        repeat (3) tick();
        check("reset_values", all_out(), RESET_VAL);
        rst = 1'b0;
        bus.tx_en = 1'b1;
        tick();

        // Single word: two-cycle latency, two-cycle start, busy until qvld rise.
        write_word(8'hA5, 1);
        check("lat_no_start_yet", {bus.start, bus.level}, {1'b0, 3'd1});
        tick();
        check("lat_start", {bus.start, bus.din, bus.level}, {1'b1, 8'hA5, 3'd0});
        serve_frame();
        check("underrun_single", bus.underrun, 1);
        bus.clr_status = 1'b1;
        tick();
        bus.clr_status = 1'b0;
        check("underrun_cleared", bus.underrun, 0);

        // Three back-to-back words, three frames.
        p0 = n_pulses;
        write_word(8'h11, 1);
        write_word(8'h22, 1);
        write_word(8'h33, 1);
        repeat (3) serve_frame();
        check("three_pulses", n_pulses - p0, 3);
        check("underrun_after_three", {bus.underrun, bus.level}, {1'b1, 3'd0});

        // Status vectors: fill, overflow, clear, set-wins, write during pop while full.
        foreach (tbl[i]) begin
            bus.tx_en      = tbl[i].tx_en;
            bus.wr_en      = tbl[i].wr_en;
            bus.wr_data    = tbl[i].wr_data;
            bus.clr_status = tbl[i].clr;
            if (tbl[i].wr_en && tbl[i].acc) sb.push_back(tbl[i].wr_data);
            tick();
            check($sformatf("vec%0d", i),
                  {bus.level, bus.full, bus.empty, bus.overflow, bus.underrun},
                  tbl[i].exp_status);
        end
        bus.wr_en = 1'b0;
        bus.clr_status = 1'b0;
        repeat (5) serve_frame();
        check("drain_done", {bus.level, bus.underrun, bus.overflow}, {3'd0, 1'b1, 1'b0});

        // Flush in LOAD with three words still queued.
        bus.clr_status = 1'b1;
        bus.tx_en = 1'b0;
        tick();
        bus.clr_status = 1'b0;
        write_word(8'hB1, 1);
        write_word(8'hB2, 1);
        write_word(8'hB3, 1);
        write_word(8'hB4, 1);
        bus.tx_en = 1'b1;
        tick();
        check("pre_flush_load", {bus.start, bus.level}, {1'b1, 3'd3});
        bus.flush = 1'b1;
        abort_ok  = 1;
        tick();
        bus.flush = 1'b0;
        sb.delete();
        frame_open = 0;
        check("flush_state", {bus.start, bus.level, bus.empty, bus.busy, bus.din},
              {1'b0, 3'd0, 1'b1, 1'b0, 8'hB1});
        tick();
        tick();
        check("flush_no_relaunch", bus.start, 0);
        write_word(8'h5A, 1);
        serve_frame();

        // Reset while BUSY.
        write_word(8'h3C, 1);
        launch_to_busy();
        check("pre_reset_busy", bus.busy, 1);
        rst = 1'b1;
        tick();
        check("reset_mid_frame", all_out(), RESET_VAL);
        tick();
        check("no_start_in_reset", bus.start, 0);
        rst = 1'b0;
        frame_open = 0;
        seen = 0;
        repeat (6) begin
            tick();
            if (bus.start) seen++;
        end
        check("no_start_after_reset", seen, 0);
        write_word(8'h77, 1);
        serve_frame();
        check("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_slave_tx_feeder.md
Name: spi_slave_tx_feeder

Overview:
- Upstream stage of the SPI slave transmitter.
- Buffers words written by the AXI register side in a FIFO and presents them one at a time on the transmitter's din/start inputs.
- Paces hand-off using the transmitter's state_tx and qvld outputs, so that exactly one word is launched per SPI frame.
- Reports level, overflow and underrun status back to the register side.

Parameters:
- data_len, 8, word width; must equal the transmitter's data_len.
- fifo_depth, 16, FIFO entries; power of two, 2..256.
- start_cycles, 2, clk cycles that start is held high per launch; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tx_en  in  1  enables launching; mirrors the transmitter's tx_en.
- flush  in  1  one-cycle pulse; empties the FIFO and aborts any launch.
- wr_en  in  1  write strobe from the register side.
- wr_data  in  data_len  word to enqueue.
- clr_status  in  1  one-cycle pulse; clears the sticky flags.
- state_tx  in  5  transmitter load-FSM state; 0 = idle.
- qvld  in  1  transmitter frame-complete level.
- din  out  data_len  word presented to the transmitter.
- start  out  1  launch strobe to the transmitter.
- level  out  clog2(fifo_depth)+1  current FIFO occupancy.
- full  out  1  level == fifo_depth.
- empty  out  1  level == 0.
- overflow  out  1  sticky: a write was dropped.
- underrun  out  1  sticky: a frame completed with the FIFO empty.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: din=0, start=0, level=0, empty=1, full=0, overflow=0, underrun=0, busy=0. FSM goes to IDLE; FIFO pointers go to 0; qvld_d goes to 0.
- FIFO:
  - Circular buffer; read and write pointers wrap at fifo_depth.
  - Write is accepted when wr_en is high and either not full, or a pop occurs in the same cycle.
  - A rejected write leaves the contents unchanged and sets overflow.
  - Simultaneous accepted write and pop leaves level unchanged.
- qvld_d is a one-cycle register of qvld. qv_rise = qvld & ~qvld_d.
- FSM:
  - IDLE: if tx_en & ~empty & state_tx==0, pop the head into din and go to LOAD. The pop takes effect the same cycle; din is registered.
  - LOAD: start=1; counter counts start_cycles cycles. Then start=0 and go to ARM. din is held stable throughout.
  - ARM: wait for state_tx!=0 (the transmitter has accepted the word). Then go to HANDOFF.
  - HANDOFF: wait for state_tx==0 (the word has moved to the shift register). Then go to BUSY.
  - BUSY: on qv_rise go to IDLE. If empty at that edge, set underrun.
  - din holds its last value in all states; it changes only on a pop.
- Latency: a write into an empty FIFO while the transmitter is idle gives start=1 two cycles after wr_en (1 cycle write, 1 cycle pop/register).
- tx_en low: IDLE does not launch. Other states continue so that handshakes already in flight complete. start is still forced low if tx_en drops during LOAD; the FSM stays in LOAD with the counter frozen until tx_en returns.
- flush: has priority over wr_en and pop in the same cycle. Pointers and level go to 0, start goes to 0, FSM goes to IDLE. din is retained. Sticky flags are unaffected.
- clr_status: clears overflow and underrun. A set event in the same cycle wins, so the flag stays 1.
- Reset mid-frame: the block returns to reset values in the cycle after rst is sampled high. No start pulse is emitted while rst is high.
- Widths: level is unsigned. Pointers are clog2(fifo_depth) bits, and the extra level bit distinguishes full from empty.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=0, LOAD=1, ARM=2, HANDOFF=3, BUSY=4; 3 bits.
  - The clog2 helper function.
  - The TX_IDLE constant (state_tx == 5'd0).
- One sub-module, spi_sync_fifo: parameterised synchronous FIFO with wr/rd/flush, level, full and empty. The top module holds the FSM, the qvld edge detector and the sticky flags.

Test Plan:
- Reset, then write 0xA5; model transmitter idle -> start high for exactly 2 cycles with din=0xA5; level returns 0; busy=1 until a qvld rise is driven.
- Write 0x11, 0x22, 0x33 back-to-back; model transmitter runs 3 frames -> din sequence 0x11, 0x22, 0x33; exactly 3 start pulses; no pulse before each qvld rise; underrun=1 after the third frame.
- fifo_depth=4: write 5 words with no launches (tx_en=0) -> level=4, full=1, overflow=1; FIFO holds the first 4 words. clr_status -> overflow=0.
- Full FIFO with tx_en=1: write in the same cycle as the pop -> write accepted; level stays 4; overflow stays 0.
- Flush asserted during LOAD with 3 words queued -> start=0 next cycle, level=0, FSM IDLE; a subsequent write 0x5A launches with din=0x5A.
- rst asserted during BUSY -> all outputs at reset values; no start pulse after rst is released until a new write arrives.
